// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the RAM arbiter.
//   arb_state_e          - arbiter FSM states (IDLE, ACCESS)
//   RAM_ADDR_W / DATA_W  - data RAM geometry (64 KB, byte wide)
//   DEFAULT_NUM_REQ      - default number of requesters
//   DEFAULT_LOCK_TIMEOUT - default idle cycles before a held lock is dropped
package ram_arb_pkg;

    localparam int RAM_ADDR_W           = 16;
    localparam int RAM_DATA_W           = 8;
    localparam int DEFAULT_NUM_REQ      = 2;
    localparam int DEFAULT_LOCK_TIMEOUT = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester, RAM and status signals of the RAM arbiter.
//   req_valid/we/lock [N]   requester controls
//   req_addr  [16N]         packed addresses, requester i at [16i+15:16i]
//   req_wdata [8N]          packed write data, requester i at [8i+7:8i]
//   req_ready [N]           one-hot accept
//   rsp_valid [N]/rsp_rdata one-cycle completion pulse and read data
//   ram_*                   single-port RAM pins (ram_data_out from RAM)
//   grant_id/busy/lock_active/dbg_state  status and FSM state
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready may depend combinationally on
// req_valid; a requester holds valid, we, addr, wdata and lock stable until
// it sees ready, and the arbiter never drops a pending request.
// Modports: slave = arbiter view, master = requesters plus RAM view.
interface ram_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_we;
    logic [16*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0]  req_wdata;
    logic [NUM_REQ-1:0]    req_lock;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [7:0]            rsp_rdata;
    logic [15:0]           ram_addr;
    logic [7:0]            ram_data_in;
    logic                  ram_write_enable;
    logic                  ram_read_enable;
    logic [7:0]            ram_data_out;
    logic [1:0]            grant_id;
    logic                  busy;
    logic                  lock_active;
    ram_arb_pkg::arb_state_e dbg_state;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_lock, ram_data_out,
        output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_data_in,
               ram_write_enable, ram_read_enable, grant_id, busy, lock_active,
               dbg_state
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_lock, ram_data_out,
        input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_data_in,
               ram_write_enable, ram_read_enable, grant_id, busy, lock_active,
               dbg_state
    );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i  [N]  request vector
//   mask_i [N]  eligibility mask
//   last_i      index of the previous winner; search starts at last_i+1
//   gnt_o  [N]  one-hot grant (zero when nothing eligible requests)
//   idx_o       index of the granted requester
//   any_o       a grant was made
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [1:0]         last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [1:0]         idx_o,
    output logic               any_o
);

    // Walk priority positions last+1 .. last+NUM_REQ (mod NUM_REQ); the inner
    // loop keeps every index constant so no variable bit-select is needed.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any_o && (((int'(last_i) + k) % NUM_REQ) == i) &&
                    req_i[i] && mask_i[i]) begin
                    gnt_o[i] = 1'b1;
                    idx_o    = 2'(i);
                    any_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing a single-port 64 KB byte RAM
// between NUM_REQ requesters, with an optional ownership lock for
// read-modify-write sequences.
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    ram_arbiter_if.slave: requester handshake, RAM pins, status
// One access takes two cycles: accept in IDLE, drive the RAM in ACCESS, and
// the response pulse appears in the following IDLE cycle, which can already
// accept the next request.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
) (
    input  logic           clk,
    input  logic           reset,
    ram_arbiter_if.slave   bus
);

    arb_state_e            state_q, state_d;
    logic [RAM_ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic [RAM_DATA_W-1:0] acc_wdata_q, acc_wdata_d;
    logic                  acc_we_q, acc_we_d;
    logic                  acc_lock_q, acc_lock_d;
    logic [NUM_REQ-1:0]    acc_gnt_q, acc_gnt_d;
    logic [1:0]            grant_id_q, grant_id_d;
    logic [1:0]            last_grant_q, last_grant_d;
    logic                  lock_active_q, lock_active_d;
    logic [NUM_REQ-1:0]    owner_q, owner_d;
    logic [7:0]            idle_cnt_q, idle_cnt_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [RAM_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    pick_gnt;
    logic [1:0]            pick_idx;
    logic                  pick_any;
    logic [7:0]            idle_cnt_inc;

    // While locked only the owner (held one-hot) may win.
    assign elig         = lock_active_q ? owner_q : '1;
    assign idle_cnt_inc = idle_cnt_q + 8'd1;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i  (bus.req_valid),
        .mask_i (elig),
        .last_i (last_grant_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            acc_addr_q    <= '0;
            acc_wdata_q   <= '0;
            acc_we_q      <= 1'b0;
            acc_lock_q    <= 1'b0;
            acc_gnt_q     <= '0;
            grant_id_q    <= '0;
            last_grant_q  <= 2'(NUM_REQ - 1);
            lock_active_q <= 1'b0;
            owner_q       <= '0;
            idle_cnt_q    <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            acc_addr_q    <= acc_addr_d;
            acc_wdata_q   <= acc_wdata_d;
            acc_we_q      <= acc_we_d;
            acc_lock_q    <= acc_lock_d;
            acc_gnt_q     <= acc_gnt_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            lock_active_q <= lock_active_d;
            owner_q       <= owner_d;
            idle_cnt_q    <= idle_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_addr_d    = acc_addr_q;
        acc_wdata_d   = acc_wdata_q;
        acc_we_d      = acc_we_q;
        acc_lock_d    = acc_lock_q;
        acc_gnt_d     = acc_gnt_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        lock_active_d = lock_active_q;
        owner_d       = owner_q;
        idle_cnt_d    = idle_cnt_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_gnt[i]) begin
                            acc_addr_d  = bus.req_addr[16*i +: 16];
                            acc_wdata_d = bus.req_wdata[8*i +: 8];
                            acc_we_d    = bus.req_we[i];
                            acc_lock_d  = bus.req_lock[i];
                        end
                    end
                    acc_gnt_d    = pick_gnt;
                    grant_id_d   = pick_idx;
                    last_grant_d = pick_idx;
                    idle_cnt_d   = '0;
                    if (|(bus.req_lock & pick_gnt)) begin
                        lock_active_d = 1'b1;
                        owner_d       = pick_gnt;
                    end
                    state_d = ACCESS;
                end else if (lock_active_q) begin
                    // No grant while locked means the owner is idle.
                    if (idle_cnt_inc == 8'(LOCK_TIMEOUT)) begin
                        lock_active_d = 1'b0;
                        idle_cnt_d    = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_inc;
                    end
                end
            end
            ACCESS: begin
                rsp_valid_d = acc_gnt_q;
                // Only capture while the RAM is actively driving the bus.
                if (!acc_we_q) begin
                    rsp_rdata_d = bus.ram_data_out;
                end
                // The owner releases by making an access with lock low.
                if (!acc_lock_q) begin
                    lock_active_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready        = (state_q == IDLE && !reset) ? pick_gnt : '0;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_rdata        = rsp_rdata_q;
    assign bus.ram_addr         = (state_q == ACCESS) ? acc_addr_q : '0;
    assign bus.ram_data_in      = (state_q == ACCESS) ? acc_wdata_q : '0;
    assign bus.ram_write_enable = (state_q == ACCESS) && acc_we_q;
    assign bus.ram_read_enable  = (state_q == ACCESS) && !acc_we_q;
    assign bus.grant_id         = grant_id_q;
    assign bus.busy             = (state_q == ACCESS);
    assign bus.lock_active      = lock_active_q;
    assign bus.dbg_state        = state_q;

endmodule
